// File: rtl/failover_sequencer.sv
// Supervisory A/B CPU failover controller: picks the active CPU and sequences recovery of the standby.
// Optional `FAILOVER_POWER_CYCLE_EN: the standby is power-cycled before each reset pulse.
module failover_sequencer #(
  parameter int HOLDOFF_CYC = 1000,
  parameter int RESET_CYC   = 256,
  parameter int BOOT_CYC    = 50000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_a,
  input  logic       io_b,
  input  logic       cmd_swi,
  input  logic       force_swi,
  input  logic       debug_mode,
  output logic       switch,
  output logic       reset_A,
  output logic       reset_B,
  output logic       power_on_A,
  output logic       power_on_B,
  output logic       fail_latched_A,
  output logic       fail_latched_B,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    RUN      = 3'd1,
    FLT_ACT  = 3'd2,
    FLT_STB  = 3'd3,
    RST_STB  = 3'd4,
    BOOT_STB = 3'd5,
    DEAD     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYC - 1);
  localparam logic [1:0]       MAX_R     = 2'(MAX_RETRY);
`ifdef FAILOVER_POWER_CYCLE_EN
  localparam logic [CNT_W-1:0] RSTB_LAST = CNT_W'(2 * RESET_CYC - 1);
`else
  localparam logic [CNT_W-1:0] RSTB_LAST = CNT_W'(RESET_CYC - 1);
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_switch;
  logic [1:0]       r_rst;   // per-CPU vectors, bit 0 = A, bit 1 = B
  logic [1:0]       r_pwr;
  logic [1:0]       r_fail;
  logic [1:0]       r_retry;

  logic             w_act;
  logic             w_stb;
  logic             w_io_act;
  logic             w_io_stb;
  logic             w_fail_stb;
  logic             w_force;
  logic [CNT_W-1:0] w_timer_inc;

  assign w_act       = r_switch;
  assign w_stb       = ~r_switch;
  assign w_io_act    = r_switch ? io_b : io_a;
  assign w_io_stb    = r_switch ? io_a : io_b;
  assign w_fail_stb  = r_fail[w_stb];
  assign w_force     = force_swi && (cmd_swi != r_switch);
  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PWRUP;
      r_timer  <= '0;
      r_switch <= 1'b0;
      r_rst    <= 2'b11;
      r_pwr    <= 2'b11;
      r_fail   <= 2'b00;
      r_retry  <= 2'd0;
    end else if (debug_mode) begin
      // Sequencing is frozen; only a manual owner change is honoured.
      if (w_force) r_switch <= ~r_switch;
    end else begin
      r_timer <= w_timer_inc;
      case (r_state)
        PWRUP: begin
          if (r_timer == RST_LAST) begin
            r_rst   <= 2'b00;
            r_state <= RUN;
            r_timer <= '0;
          end
        end
        RUN: begin
          if (!w_io_act) begin
            r_state <= FLT_ACT;
            r_timer <= '0;
          end else if (w_force && w_io_stb) begin
            r_switch <= ~r_switch;
          end else if (!w_io_stb && !w_fail_stb) begin
            r_state <= FLT_STB;
            r_timer <= '0;
          end
        end
        FLT_ACT: begin
          if (w_io_act) begin
            r_state <= RUN;
            r_timer <= '0;
          end else if (r_timer == HOLD_LAST) begin
            r_timer <= '0;
            if (w_io_stb && !w_fail_stb) begin
              // Hand over to the healthy standby; the failed CPU becomes the new standby.
              r_switch     <= ~r_switch;
              r_retry      <= 2'd1;
              r_rst[w_act] <= 1'b1;
`ifdef FAILOVER_POWER_CYCLE_EN
              r_pwr[w_act] <= 1'b0;
`endif
              r_state      <= RST_STB;
            end else begin
              r_state <= DEAD;
            end
          end
        end
        FLT_STB: begin
          if (w_io_stb) begin
            r_state <= RUN;
            r_timer <= '0;
          end else if (r_timer == HOLD_LAST) begin
            r_retry      <= 2'd1;
            r_rst[w_stb] <= 1'b1;
`ifdef FAILOVER_POWER_CYCLE_EN
            r_pwr[w_stb] <= 1'b0;
`endif
            r_state      <= RST_STB;
            r_timer      <= '0;
          end
        end
        RST_STB: begin
`ifdef FAILOVER_POWER_CYCLE_EN
          if (r_timer == RST_LAST) r_pwr[w_stb] <= 1'b1;
`endif
          if (r_timer == RSTB_LAST) begin
            r_rst[w_stb] <= 1'b0;
            r_state      <= BOOT_STB;
            r_timer      <= '0;
          end
        end
        BOOT_STB: begin
          if (w_io_stb) begin
            r_retry <= 2'd0;
            r_state <= RUN;
            r_timer <= '0;
          end else if (r_timer == BOOT_LAST) begin
            r_timer <= '0;
            if (r_retry < MAX_R) begin
              r_retry      <= r_retry + 2'd1;
              r_rst[w_stb] <= 1'b1;
`ifdef FAILOVER_POWER_CYCLE_EN
              r_pwr[w_stb] <= 1'b0;
`endif
              r_state      <= RST_STB;
            end else begin
              // Out of retries: park the standby powered off until the next rst_n.
              r_fail[w_stb] <= 1'b1;
              r_pwr[w_stb]  <= 1'b0;
              r_state       <= RUN;
            end
          end
        end
        DEAD: begin
          r_rst <= 2'b00;
          if (io_a && !r_fail[0]) begin
            r_switch <= 1'b0;
            r_state  <= RUN;
            r_timer  <= '0;
          end else if (io_b && !r_fail[1]) begin
            r_switch <= 1'b1;
            r_state  <= RUN;
            r_timer  <= '0;
          end
        end
        default: begin
          r_state <= RUN;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign switch         = r_switch;
  assign reset_A        = r_rst[0];
  assign reset_B        = r_rst[1];
  assign power_on_A     = r_pwr[0];
  assign power_on_B     = r_pwr[1];
  assign fail_latched_A = r_fail[0];
  assign fail_latched_B = r_fail[1];
  assign retry_cnt      = r_retry;
  assign state          = r_state;

endmodule
